stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 4-digit BCD stopwatch counter from three raw push-buttons (go, lap, reset). It conditions the buttons and drives the counter's `start` (run enable) and `clear_in` (synchronous zero) inputs. It also monitors the counter's digits, freezes a lap snapshot for display and stops automatically at 9999. It sits between the board buttons and the counter, and its display digits feed the seven-segment mux.

Parameters:
- DB_CYCLES, 2_000_000, cycles a synchronized button must be stable before it is accepted (20 ms at 100 MHz); benches use 4.
- STOP_AT_MAX, 1, 1 = auto-pause and set `overflow` when live digits reach 9999; 0 = let the counter wrap to 0000.

Ports:
- clk  in  1  system clock.
- clear  in  1  synchronous active-high reset.
- btn_go  in  1  raw asynchronous button: run/pause toggle.
- btn_lap  in  1  raw asynchronous button: lap freeze/release.
- btn_rst  in  1  raw asynchronous button: zero the count (honoured only when stopped).
- d0_in, d1_in, d2_in, d3_in  in  4 each  live BCD digits from the counter (d0 = least significant).
- start  out  1  counter run enable; high in RUN and LAP.
- clear_in  out  1  one-cycle pulse that zeroes the counter.
- disp0, disp1, disp2, disp3  out  4 each  digits to display (lap snapshot or live).
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- overflow  out  1  sticky; set on auto-stop at 9999.

Behaviour:
- Reset: one clock with `clear` high gives the following:
  - state = IDLE; `start`, `clear_in`, `overflow` = 0.
  - lap register = 0000.
  - debounce counters and synchronizers = 0, and no button pulses are emitted.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level accepted after DB_CYCLES consecutive equal samples; counter width is $clog2(DB_CYCLES+1).
  - 1-cycle `*_p` pulse on the 0->1 transition of the debounced level. Holding a button gives exactly one pulse.
- FSM states: IDLE (stopped, zeroed), RUN, LAP (running, display frozen), PAUSE.
- Priority when pulses coincide in the same cycle: rst_p > go_p > lap_p. Exactly one event is acted on per cycle.
- IDLE:
  - go_p -> RUN.
  - rst_p -> IDLE and pulse `clear_in`.
  - lap_p ignored.
- RUN:
  - go_p -> PAUSE.
  - lap_p -> LAP, and the lap register captures d3_in..d0_in in the same clock edge.
  - rst_p ignored.
- LAP:
  - lap_p -> RUN, releasing the display.
  - go_p -> PAUSE; the display reverts to live digits.
  - rst_p ignored.
- PAUSE:
  - go_p -> RUN.
  - rst_p -> IDLE, pulse `clear_in`, and clear `overflow`.
  - lap_p ignored.
- Auto-stop (STOP_AT_MAX=1):
  - In RUN or LAP, live digits == 9,9,9,9 -> PAUSE next cycle and set `overflow`.
  - This has priority over all button pulses.
  - `start` falls one cycle after 9999 is first seen. The counter's sub-tick then stops, so it never wraps.
- Outputs are Moore and registered:
  - `start` and `running` = (state_reg in {RUN, LAP}).
  - `lap_active` = (state_reg == LAP).
  - `clear_in` is a registered flag, so it is high for exactly the one cycle after the transition edge.
- Latency: raw press to `start` rising = 2 (sync) + DB_CYCLES + 1 (pulse) + 1 (state) cycles.
- Display: disp = lap_active ? lap register : live inputs (combinational mux). The lap register holds its last value outside LAP.
- Reset mid-operation (`clear` in RUN):
  - IDLE next cycle; `start` = 0; `clear_in` = 0.
  - The counter is reset separately by the same `clear`.
- Glitches shorter than DB_CYCLES produce no pulse.

Decomposition:
- Package stopwatch_pkg:
  - typedef bcd_t = logic [3:0].
  - enum sw_state_t {IDLE, RUN, LAP, PAUSE}.
  - constant BCD_MAX = 4'd9.
- Sub-module btn_cond, instantiated 3 times:
  - Parameter DB_CYCLES.
  - Ports clk, clear, btn_raw, level, pulse.
  - Contains the synchronizer, debounce counter and rising-edge detector.
- The top level holds the FSM, the lap register and the display mux.

Test Plan (DB_CYCLES=4, STOP_AT_MAX=1):
- Reset -> state IDLE; start=0, clear_in=0, overflow=0, disp=0000. Hold btn_go high for 3 cycles only -> no go_p, start stays 0.
- Press btn_go (held 20 cycles) -> start rises exactly 2+4+1+1 = 8 cycles after the raw edge, single go_p. Press again -> start=0 (PAUSE). Press btn_rst -> clear_in high for exactly 1 cycle, state IDLE.
- In RUN with live digits 0,3,2,1 (d3..d0), press btn_lap -> lap_active=1, disp holds 0,3,2,1 while inputs advance to 0,3,2,5. Press btn_lap -> disp follows live digits.
- In RUN, press btn_rst -> ignored: start stays 1, clear_in stays 0. go and rst pulses forced in the same cycle while in PAUSE -> IDLE with clear_in pulse, start stays 0.
- Drive live digits to 9,9,9,9 in RUN -> next cycle start=0, overflow=1, state PAUSE. btn_go -> RUN. Back in PAUSE, btn_rst -> overflow=0, clear_in pulse.
- Assert `clear` for 1 cycle while in LAP -> next cycle start=0, lap_active=0, disp0-3=0000 (live inputs driven 0000), no clear_in pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
//   bcd_t       : one BCD digit
//   sw_state_t  : control FSM state encoding
//   BCD_MAX     : largest legal BCD digit value
//   is_bcd_max  : true when a digit holds BCD_MAX
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic is_bcd_max(input bcd_t d);
    return (d == BCD_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Conditions one raw push-button: 2-flop synchronizer, debounce counter and
// registered rising-edge pulse.
//   clk      : system clock
//   clear    : synchronous active-high reset
//   btn_raw  : asynchronous raw button level
//   level    : debounced button level
//   pulse    : one-cycle pulse on each accepted 0->1 transition of level
module btn_cond #(
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tracks consecutive samples that disagree with the accepted
  // level; the new level is taken on the DB_CYCLES-th such sample.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Edge detect on the registered level, so the pulse is itself a flop.
      pulse_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions the go/lap/reset buttons, drives the BCD
// counter's run enable and synchronous clear, freezes a lap snapshot for the
// display and optionally auto-stops at 9999.
//   clk, clear           : clock, synchronous active-high reset
//   btn_go/lap/rst       : raw asynchronous buttons
//   d0_in..d3_in         : live BCD digits from the counter (d0 = LSD)
//   start                : counter run enable (RUN or LAP)
//   clear_in             : one-cycle counter zero pulse
//   disp0..disp3         : displayed digits (lap snapshot in LAP, else live)
//   running, lap_active  : state indicators
//   overflow             : sticky auto-stop flag
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 2_000_000,
  parameter bit          STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       btn_go,
  input  logic       btn_lap,
  input  logic       btn_rst,
  input  logic [3:0] d0_in,
  input  logic [3:0] d1_in,
  input  logic [3:0] d2_in,
  input  logic [3:0] d3_in,
  output logic       start,
  output logic       clear_in,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  logic [2:0] btn_level_unused;
  logic       go_p;
  logic       lap_p;
  logic       rst_p;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_go (
    .clk     (clk),
    .clear   (clear),
    .btn_raw (btn_go),
    .level   (btn_level_unused[0]),
    .pulse   (go_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_lap (
    .clk     (clk),
    .clear   (clear),
    .btn_raw (btn_lap),
    .level   (btn_level_unused[1]),
    .pulse   (lap_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_rst (
    .clk     (clk),
    .clear   (clear),
    .btn_raw (btn_rst),
    .level   (btn_level_unused[2]),
    .pulse   (rst_p)
  );

  sw_state_t        state_q;
  sw_state_t        state_d;
  logic             clear_in_q;
  logic             clear_in_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             lap_cap;
  bcd_t [3:0]       lap_q;
  bcd_t [3:0]       live;
  logic             at_max;
  logic             counting;

  assign live     = {d3_in, d2_in, d1_in, d0_in};
  assign at_max   = is_bcd_max(d3_in) && is_bcd_max(d2_in) &&
                    is_bcd_max(d1_in) && is_bcd_max(d0_in);
  assign counting = (state_q == RUN) || (state_q == LAP);

  // Auto-stop outranks every button; otherwise per-state priority is
  // rst > go > lap, with events that a state ignores simply falling through.
  always_comb begin
    state_d    = state_q;
    clear_in_d = 1'b0;
    overflow_d = overflow_q;
    lap_cap    = 1'b0;
    if (STOP_AT_MAX && counting && at_max) begin
      state_d    = PAUSE;
      overflow_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rst_p) begin
            clear_in_d = 1'b1;
          end else if (go_p) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (go_p) begin
            state_d = PAUSE;
          end else if (lap_p) begin
            state_d = LAP;
            lap_cap = 1'b1;
          end
        end
        LAP: begin
          if (go_p) begin
            state_d = PAUSE;
          end else if (lap_p) begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (rst_p) begin
            state_d    = IDLE;
            clear_in_d = 1'b1;
            overflow_d = 1'b0;
          end else if (go_p) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      clear_in_q <= 1'b0;
      overflow_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      clear_in_q <= clear_in_d;
      overflow_q <= overflow_d;
      if (lap_cap) begin
        lap_q <= live;
      end
    end
  end

  assign start      = counting;
  assign running    = counting;
  assign lap_active = (state_q == LAP);
  assign clear_in   = clear_in_q;
  assign overflow   = overflow_q;

  assign disp0 = lap_active ? lap_q[0] : d0_in;
  assign disp1 = lap_active ? lap_q[1] : d1_in;
  assign disp2 = lap_active ? lap_q[2] : d2_in;
  assign disp3 = lap_active ? lap_q[3] : d3_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       btn_go, btn_lap, btn_rst;
  logic [3:0] d0_in, d1_in, d2_in, d3_in;
  logic       start, clear_in, running, lap_active, overflow;
  logic [3:0] disp0, disp1, disp2, disp3;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DB_CYCLES   (4),
    .STOP_AT_MAX (1'b1)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .btn_go     (btn_go),
    .btn_lap    (btn_lap),
    .btn_rst    (btn_rst),
    .d0_in      (d0_in),
    .d1_in      (d1_in),
    .d2_in      (d2_in),
    .d3_in      (d3_in),
    .start      (start),
    .clear_in   (clear_in),
    .disp0      (disp0),
    .disp1      (disp1),
    .disp2      (disp2),
    .disp3      (disp3),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  localparam int S_START = 0;
  localparam int S_CLR   = 1;
  localparam int S_RUN   = 2;
  localparam int S_LAP   = 3;
  localparam int S_OVF   = 4;
  localparam int S_DISP  = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_START: return {15'd0, start};
      S_CLR:   return {15'd0, clear_in};
      S_RUN:   return {15'd0, running};
      S_LAP:   return {15'd0, lap_active};
      S_OVF:   return {15'd0, overflow};
      default: return {disp3, disp2, disp1, disp0};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [3:0] a3, input logic [3:0] a2,
                          input logic [3:0] a1, input logic [3:0] a0);
    d3_in = a3; d2_in = a2; d1_in = a1; d0_in = a0;
  endtask

  // Hold the chosen raw buttons for 'hold' cycles, release, let the release
  // debounce out; count clear_in-high and start-high cycles along the way.
  task automatic press(input logic g, input logic l, input logic r, input int hold,
                       output int n_clr, output int n_st);
    n_clr = 0;
    n_st  = 0;
    btn_go = g; btn_lap = l; btn_rst = r;
    for (int i = 0; i < hold; i++) begin
      step();
      if (clear_in) n_clr++;
      if (start) n_st++;
    end
    btn_go = 1'b0; btn_lap = 1'b0; btn_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (clear_in) n_clr++;
      if (start) n_st++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, ns, lat;
    clear = 1'b1;
    btn_go = 1'b0; btn_lap = 1'b0; btn_rst = 1'b0;
    set_live(0, 0, 0, 0);
    step();
    clear = 1'b0;

    expect_out("rst_start", S_START, 16'd0);
    expect_out("rst_clr",   S_CLR,   16'd0);
    expect_out("rst_ovf",   S_OVF,   16'd0);
    expect_out("rst_lap",   S_LAP,   16'd0);
    expect_out("rst_disp",  S_DISP,  16'h0000);
    sb_check();

    // 3-cycle glitch must not be accepted
    press(1'b1, 1'b0, 1'b0, 3, nc, ns);
    check_eq("glitch_start_cycles", 16'(ns), 16'd0);
    expect_out("glitch_start", S_START, 16'd0);
    sb_check();

    // go latency: 2 sync + 4 debounce + 1 pulse + 1 state
    btn_go = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (start && lat == 0) lat = k;
    end
    check_eq("go_latency", 16'(lat), 16'd8);
    expect_out("go_held_start", S_START, 16'd1);
    btn_go = 1'b0;
    sb_check();
    repeat (12) step();
    expect_out("go_run_start", S_START, 16'd1);
    expect_out("go_running",   S_RUN,   16'd1);
    sb_check();

    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    expect_out("pause_start", S_START, 16'd0);
    expect_out("pause_run",   S_RUN,   16'd0);
    sb_check();

    press(1'b0, 1'b0, 1'b1, 12, nc, ns);
    check_eq("pause_rst_clr_cycles", 16'(nc), 16'd1);
    check_eq("pause_rst_start_cycles", 16'(ns), 16'd0);

    // lap freeze / release
    set_live(0, 3, 2, 1);
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    expect_out("lap_pre_start", S_START, 16'd1);
    sb_check();
    press(1'b0, 1'b1, 1'b0, 12, nc, ns);
    expect_out("lap_active", S_LAP,   16'd1);
    expect_out("lap_start",  S_START, 16'd1);
    expect_out("lap_disp",   S_DISP,  16'h0321);
    sb_check();
    set_live(0, 3, 2, 5);
    repeat (3) step();
    expect_out("lap_frozen_disp", S_DISP, 16'h0321);
    sb_check();
    press(1'b0, 1'b1, 1'b0, 12, nc, ns);
    expect_out("lap_release", S_LAP,  16'd0);
    expect_out("live_disp",   S_DISP, 16'h0325);
    expect_out("lap_rel_run", S_START, 16'd1);
    sb_check();

    // rst ignored while running
    press(1'b0, 1'b0, 1'b1, 12, nc, ns);
    check_eq("run_rst_clr_cycles", 16'(nc), 16'd0);
    expect_out("run_rst_start", S_START, 16'd1);
    sb_check();

    // coincident go+rst in PAUSE: rst wins
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    expect_out("pause2_start", S_START, 16'd0);
    sb_check();
    press(1'b1, 1'b0, 1'b1, 12, nc, ns);
    check_eq("gorst_clr_cycles", 16'(nc), 16'd1);
    check_eq("gorst_start_cycles", 16'(ns), 16'd0);
    press(1'b0, 1'b1, 1'b0, 12, nc, ns);
    expect_out("idle_lap_ignored", S_LAP, 16'd0);
    sb_check();

    // auto-stop at 9999
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    set_live(9, 9, 9, 9);
    expect_out("max_seen_start", S_START, 16'd1);
    sb_check();
    step();
    expect_out("autostop_start", S_START, 16'd0);
    expect_out("autostop_ovf",   S_OVF,   16'd1);
    expect_out("autostop_run",   S_RUN,   16'd0);
    sb_check();
    set_live(9, 9, 9, 8);
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    expect_out("ovf_resume_start", S_START, 16'd1);
    expect_out("ovf_sticky",       S_OVF,   16'd1);
    sb_check();
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    expect_out("ovf_pause_start", S_START, 16'd0);
    sb_check();
    press(1'b0, 1'b0, 1'b1, 12, nc, ns);
    check_eq("ovf_rst_clr_cycles", 16'(nc), 16'd1);
    expect_out("ovf_cleared", S_OVF, 16'd0);
    sb_check();

    // clear while in LAP
    set_live(0, 1, 0, 0);
    press(1'b1, 1'b0, 1'b0, 12, nc, ns);
    press(1'b0, 1'b1, 1'b0, 12, nc, ns);
    expect_out("pre_clear_lap", S_LAP, 16'd1);
    sb_check();
    set_live(0, 0, 0, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    expect_out("clr_start", S_START, 16'd0);
    expect_out("clr_lap",   S_LAP,   16'd0);
    expect_out("clr_disp",  S_DISP,  16'h0000);
    expect_out("clr_clrin", S_CLR,   16'd0);
    sb_check();
    nc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (clear_in) nc++;
    end
    check_eq("clr_no_clr_pulse", 16'(nc), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
